pipe_hazard_ctrl: RTL

Hazard scheduler for the 5-stage IF/ID/EX/MEM/WB integer pipeline with branch delay slot.
- Keeps a shadow scoreboard of destination registers for the EX, MEM and WB stages.
- Generates registered forwarding selects for the EX operands, load-use stalls, and IF/ID flush and annul control when EX resolves a control transfer (branch, call or jmpl).
- Sits beside the pipeline registers; its outputs drive PC/IF_ID hold, the ID_EX bubble mux and the EX operand muxes.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/hz_scoreboard_stage.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Contents: forwarding-select encoding, hazard FSM states, default register
// address width and link register, and the scoreboard entry layout.
package pipe_pkg;

  localparam int unsigned REG_AW_DEF   = 5;
  localparam int unsigned LINK_REG_DEF = 15;

  // EX operand source
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    REDIR  = 2'd2
  } hz_state_t;

  // One shadow scoreboard entry: valid, destination, writes RF, is a load
  typedef struct packed {
    logic                  v;
    logic [REG_AW_DEF-1:0] rd;
    logic                  we;
    logic                  ld;
  } sb_entry_t;

endpackage

// File: rtl/hz_scoreboard_stage.sv
// One scoreboard entry register {v, rd, we, ld}.
// Ports:
//   clk, reset  clock, asynchronous active-high reset (entry invalid)
//   clear       load an all-zero (invalid) entry
//   load        capture d
//   d, q        entry in / entry out
// entry_t lets the top size rd to its own register address width.
module hz_scoreboard_stage
  import pipe_pkg::*;
#(
  parameter type entry_t = sb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline with a branch
// delay slot. Tracks EX/MEM/WB destinations in a shadow scoreboard and
// produces load-use stall/bubble, IF_ID flush after a taken control transfer,
// and registered EX operand forwarding selects.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_*                       instruction currently in ID
//   ex_take_ctrl, ex_annul     EX resolved a taken transfer / annuls delay slot
//   stall, bubble              hold PC/nPC/IF_ID, insert NOP into ID_EX
//   flush_ifid                 replace IF_ID with NOP (cycle after redirect)
//   fwd_a, fwd_b               EX operand source selects
//   stall_cnt, flush_cnt       performance counters
// Build option: define HAZARD_PERF_EN to implement the counters; otherwise
// both counter ports are tied to zero.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned LINK_REG = LINK_REG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              id_is_call,
  input  logic              ex_take_ctrl,
  input  logic              ex_annul,
  output logic              stall,
  output logic              bubble,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } sb_ent_t;

  localparam logic [REG_AW-1:0] LINK_RD = REG_AW'(LINK_REG);

  sb_ent_t   id_e, ex_q, mem_q, wb_q;
  hz_state_t state;
  logic      flush_q;
  fwd_sel_t  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic      lu_hit, lu_stall, annul_bubble, kill_ex;
  logic      unused_wb_ld;

  function automatic logic hit(input sb_ent_t e, input logic used,
                               input logic [REG_AW-1:0] rs);
    return used & e.v & e.we & (e.rd != '0) & (rs == e.rd);
  endfunction

  always_comb begin
    id_e.v  = id_valid;
    id_e.rd = id_is_call ? LINK_RD : id_rd;
    id_e.we = id_we | id_is_call;
    id_e.ld = id_is_load & ~id_is_call;
  end

  assign lu_hit = ex_q.ld & (hit(ex_q, id_use1, id_rs1) | hit(ex_q, id_use2, id_rs2));
  // A redirect in EX overrides the load-use hazard of the instruction in ID
  assign lu_stall     = (state == RUN) & lu_hit & ~ex_take_ctrl;
  assign annul_bubble = ex_take_ctrl & ex_annul;
  // Anything that keeps the ID instruction out of EX: stall, annulled delay
  // slot, or the wrong-path instruction being flushed this cycle
  assign kill_ex      = lu_stall | annul_bubble | flush_q;

  assign stall        = lu_stall;
  assign bubble       = lu_stall | annul_bubble;
  assign flush_ifid   = flush_q;
  assign fwd_a        = fwd_a_q;
  assign fwd_b        = fwd_b_q;
  assign unused_wb_ld = wb_q.ld;

  // Later assignments override earlier ones, giving youngest-first priority
  always_comb begin
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (hit(wb_q, id_use1, id_rs1))                fwd_a_d = FWD_WB;
    if (hit(wb_q, id_use2, id_rs2))                fwd_b_d = FWD_WB;
    if (hit(mem_q, id_use1, id_rs1))               fwd_a_d = FWD_MEMWB;
    if (hit(mem_q, id_use2, id_rs2))               fwd_b_d = FWD_MEMWB;
    if (hit(ex_q, id_use1, id_rs1) && !ex_q.ld)    fwd_a_d = FWD_EXMEM;
    if (hit(ex_q, id_use2, id_rs2) && !ex_q.ld)    fwd_b_d = FWD_EXMEM;
    if (kill_ex || !id_valid) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      flush_q <= 1'b0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      flush_q <= ex_take_ctrl;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      if (ex_take_ctrl) begin
        state <= REDIR;
      end else begin
        case (state)
          RUN:     state <= lu_stall ? LSTALL : RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

  hz_scoreboard_stage #(.entry_t(sb_ent_t)) u_ex (
    .clk(clk), .reset(reset), .clear(kill_ex), .load(1'b1), .d(id_e), .q(ex_q)
  );
  hz_scoreboard_stage #(.entry_t(sb_ent_t)) u_mem (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b1), .d(ex_q), .q(mem_q)
  );
  hz_scoreboard_stage #(.entry_t(sb_ent_t)) u_wb (
    .clk(clk), .reset(reset), .clear(1'b0), .load(1'b1), .d(mem_q), .q(wb_q)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (lu_stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_q && flush_cnt_q != '1)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
